// File: rtl/ip_encoder_pkg.sv
// Shared types and constants for the IPv4 header encoder.
// Header word layout helpers are shared by the checksum pass and the output pass.
package ip_encoder_pkg;

    localparam logic [15:0] MaxPayload  = 16'd65515;
    localparam logic [3:0]  Ipv4Version = 4'd4;
    localparam logic [3:0]  IhlMin      = 4'd5;
    localparam logic [15:0] HdrBytes    = 16'd20;
    localparam logic [2:0]  LastHdrIdx  = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StSum,
        StFold,
        StHdr,
        StPayload
    } state_e;

    typedef struct packed {
        logic [7:0]  tos;
        logic [15:0] total_len;
        logic [15:0] id;
        logic [2:0]  flag;
        logic [12:0] frag;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [31:0] src;
        logic [31:0] dst;
    } hdr_t;

    function automatic logic [31:0] hdr_word(hdr_t h, logic [2:0] idx, logic [15:0] chksum);
        logic [31:0] w;
        case (idx)
            3'd0:    w = {Ipv4Version, IhlMin, h.tos, h.total_len};
            3'd1:    w = {h.id, h.flag, h.frag};
            3'd2:    w = {h.ttl, h.proto, chksum};
            3'd3:    w = h.src;
            3'd4:    w = h.dst;
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // Keeps the top (len%4 ? len%4 : 4) bytes of the final payload word.
    function automatic logic [31:0] last_mask(logic [1:0] rem);
        logic [31:0] m;
        case (rem)
            2'd1:    m = 32'hff00_0000;
            2'd2:    m = 32'hffff_0000;
            2'd3:    m = 32'hffff_ff00;
            default: m = 32'hffff_ffff;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ip_encoder_if.sv
// Field/payload/stream bundle between a payload source and the IPv4 encoder.
// The master side is the frame requester; the slave side is the encoder.
interface ip_encoder_if;

    logic        start;
    logic [7:0]  type_of_ser;
    logic [15:0] payload_len;
    logic [15:0] identification;
    logic [2:0]  flag;
    logic [12:0] frag_offset;
    logic [7:0]  time_to_live;
    logic [7:0]  protocol;
    logic [31:0] src_ip;
    logic [31:0] dest_ip;
    logic [31:0] payload_data;
    logic        payload_valid;
    logic        payload_ready;
    logic [31:0] data_out;
    logic        out_valid;
    logic        fin;
    logic        busy;
    logic        err;

    modport master (
        output start, type_of_ser, payload_len, identification, flag, frag_offset,
               time_to_live, protocol, src_ip, dest_ip, payload_data, payload_valid,
        input  payload_ready, data_out, out_valid, fin, busy, err
    );

    modport slave (
        input  start, type_of_ser, payload_len, identification, flag, frag_offset,
               time_to_live, protocol, src_ip, dest_ip, payload_data, payload_valid,
        output payload_ready, data_out, out_valid, fin, busy, err
    );

endinterface

// File: rtl/ip_encoder_chksum16.sv
// 32-bit one's-complement accumulator: clear, add both halves of a word, fold to 16 bits.
// Shared with the header decoder for checksum verification.
module ip_encoder_chksum16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clr,
    input  logic        i_add,
    input  logic        i_fold,
    input  logic [31:0] i_word,
    output logic [15:0] o_chksum
);

    logic [31:0] r_acc;
    logic [15:0] r_chksum;
    logic [16:0] w_s1;
    logic [15:0] w_s2;

    // Two-step fold: the second carry add cannot overflow since w_s1 <= 0x1fffe.
    assign w_s1 = {1'b0, r_acc[15:0]} + {1'b0, r_acc[31:16]};
    assign w_s2 = w_s1[15:0] + {15'd0, w_s1[16]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= 32'd0;
            r_chksum <= 16'd0;
        end else if (i_clr) begin
            r_acc    <= 32'd0;
        end else if (i_add) begin
            r_acc    <= r_acc + {16'd0, i_word[31:16]} + {16'd0, i_word[15:0]};
        end else if (i_fold) begin
            r_chksum <= ~w_s2;
        end
    end

    assign o_chksum = r_chksum;

endmodule

// File: rtl/ip_encoder.sv
// IPv4 transmit encoder: latches header fields, computes the header checksum,
// then streams the 5-word header followed by the payload as big-endian 32-bit words.
module ip_encoder
    import ip_encoder_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    ip_encoder_if.slave  bus
);

    state_e      r_state;
    state_e      w_next;
    hdr_t        r_hdr;
    logic [15:0] r_len;
    logic [2:0]  r_idx;
    logic [15:0] r_words_left;
    logic [31:0] r_data;
    logic        r_valid;
    logic        r_fin;
    logic        r_err;

    logic        w_idle;
    logic        w_start_ok;
    logic        w_start_bad;
    logic        w_xfer;
    logic        w_last_word;
    logic        w_idx_last;
    logic [16:0] w_len_p3;
    logic [15:0] w_chksum;

    assign w_idle      = (r_state == StIdle);
    assign w_start_ok  = bus.start && w_idle && (bus.payload_len <= MaxPayload);
    assign w_start_bad = bus.start && w_idle && (bus.payload_len > MaxPayload);
    assign w_xfer      = (r_state == StPayload) && bus.payload_valid;
    assign w_last_word = (r_words_left == 16'd1);
    assign w_idx_last  = (r_idx == LastHdrIdx);
    assign w_len_p3    = {1'b0, r_len} + 17'd3;

    ip_encoder_chksum16 u_chksum (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_start_ok),
        .i_add    (r_state == StSum),
        .i_fold   (r_state == StFold),
        .i_word   (hdr_word(r_hdr, r_idx, 16'h0000)),
        .o_chksum (w_chksum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            StIdle:    if (w_start_ok) w_next = StSum;
            StSum:     if (w_idx_last) w_next = StFold;
            StFold:    w_next = StHdr;
            StHdr:     if (w_idx_last) w_next = (r_len == 16'd0) ? StIdle : StPayload;
            StPayload: if (w_xfer && w_last_word) w_next = StIdle;
            default:   w_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hdr        <= '0;
            r_len        <= 16'd0;
            r_idx        <= 3'd0;
            r_words_left <= 16'd0;
            r_data       <= 32'd0;
            r_valid      <= 1'b0;
            r_fin        <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_fin   <= 1'b0;
            r_err   <= w_start_bad;
            case (r_state)
                StIdle: begin
                    if (w_start_ok) begin
                        r_hdr.tos       <= bus.type_of_ser;
                        r_hdr.total_len <= bus.payload_len + HdrBytes;
                        r_hdr.id        <= bus.identification;
                        r_hdr.flag      <= bus.flag;
                        r_hdr.frag      <= bus.frag_offset;
                        r_hdr.ttl       <= bus.time_to_live;
                        r_hdr.proto     <= bus.protocol;
                        r_hdr.src       <= bus.src_ip;
                        r_hdr.dst       <= bus.dest_ip;
                        r_len           <= bus.payload_len;
                        r_idx           <= 3'd0;
                    end
                end
                StSum: begin
                    r_idx <= w_idx_last ? 3'd0 : r_idx + 3'd1;
                end
                StHdr: begin
                    r_data  <= hdr_word(r_hdr, r_idx, w_chksum);
                    r_valid <= 1'b1;
                    r_fin   <= w_idx_last && (r_len == 16'd0);
                    r_idx   <= w_idx_last ? 3'd0 : r_idx + 3'd1;
                    if (w_idx_last) begin
                        r_words_left <= {1'b0, w_len_p3[16:2]};
                    end
                end
                StPayload: begin
                    if (w_xfer) begin
                        r_data       <= w_last_word ? (bus.payload_data & last_mask(r_len[1:0]))
                                                    : bus.payload_data;
                        r_valid      <= 1'b1;
                        r_fin        <= w_last_word;
                        r_words_left <= r_words_left - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.payload_ready = (r_state == StPayload);
    assign bus.busy          = !w_idle;
    assign bus.data_out      = r_data;
    assign bus.out_valid     = r_valid;
    assign bus.fin           = r_fin;
    assign bus.err           = r_err;

endmodule

// File: tb/tb_ip_encoder.sv
// Randomized self-checking bench for ip_encoder against a byte-level IPv4 frame model.
module tb_ip_encoder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ip_encoder_if u_if ();

    ip_encoder u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  f_tos;
    int          f_len;
    logic [15:0] f_id;
    logic [2:0]  f_flag;
    logic [12:0] f_frag;
    logic [7:0]  f_ttl;
    logic [7:0]  f_proto;
    logic [31:0] f_src;
    logic [31:0] f_dst;
    logic [7:0]  f_pl[$];
    logic [31:0] exp_q[$];
    logic [31:0] drv_q[$];
    logic [31:0] obs_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Frame model: header from field values, checksum by one's-complement sum of 16-bit halves,
    // payload packed big-endian with zero padding. Driven words carry junk in the padding.
    function automatic void build_model();
        int unsigned s;
        logic [15:0] tl;
        logic [15:0] ck;
        logic [31:0] w;
        logic [31:0] dw;
        tl = 16'(f_len + 20);
        s  = 32'h4500 + f_tos + tl + f_id + {f_flag, f_frag} + {f_ttl, f_proto}
           + f_src[31:16] + f_src[15:0] + f_dst[31:16] + f_dst[15:0];
        while (s > 32'hffff) s = (s & 32'hffff) + (s >> 16);
        ck = ~(16'(s));
        exp_q = {};
        drv_q = {};
        exp_q.push_back({8'h45, f_tos, tl});
        exp_q.push_back({f_id, f_flag, f_frag});
        exp_q.push_back({f_ttl, f_proto, ck});
        exp_q.push_back(f_src);
        exp_q.push_back(f_dst);
        for (int i = 0; i < f_len; i += 4) begin
            w  = 32'h0;
            dw = $urandom;
            for (int b = 0; b < 4; b++) begin
                if (i + b < f_len) begin
                    w[31-8*b -: 8]  = f_pl[i+b];
                    dw[31-8*b -: 8] = f_pl[i+b];
                end
            end
            exp_q.push_back(w);
            drv_q.push_back(dw);
        end
    endfunction

    task automatic rand_fields(input int len);
        f_tos = 8'($urandom);   f_len = len;          f_id   = 16'($urandom);
        f_flag = 3'($urandom);  f_frag = 13'($urandom); f_ttl = 8'($urandom);
        f_proto = 8'($urandom); f_src = $urandom;     f_dst  = $urandom;
        f_pl = {};
        for (int i = 0; i < len; i++) f_pl.push_back(8'($urandom));
    endtask

    task automatic pulse_start();
        u_if.type_of_ser    = f_tos;
        u_if.payload_len    = 16'(f_len);
        u_if.identification = f_id;
        u_if.flag           = f_flag;
        u_if.frag_offset    = f_frag;
        u_if.time_to_live   = f_ttl;
        u_if.protocol       = f_proto;
        u_if.src_ip         = f_src;
        u_if.dest_ip        = f_dst;
        u_if.start          = 1'b1;
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
    endtask

    task automatic run_frame(input int gap_pct, input bit poke);
        int  nidx = 0;
        int  pidx = 0;
        bit  fin_seen = 0;
        bit  rdy_seen = 0;
        bit  take;
        build_model();
        pulse_start();
        obs_q = {};
        check_eq("busy_after_start", u_if.busy, 1);
        for (int cyc = 1; cyc <= 400 && !fin_seen; cyc++) begin
            if (poke && cyc == 3) begin
                u_if.start       = 1'b1;
                u_if.type_of_ser = ~f_tos;
                u_if.payload_len = 16'd0;
            end
            if (pidx < drv_q.size() && $urandom_range(99) >= gap_pct) begin
                u_if.payload_valid = 1'b1;
                u_if.payload_data  = drv_q[pidx];
            end else begin
                u_if.payload_valid = 1'b0;
                u_if.payload_data  = $urandom;
            end
            take = u_if.payload_valid && u_if.payload_ready;
            if (u_if.payload_ready) rdy_seen = 1;
            @(posedge clk);
            #1;
            u_if.start = 1'b0;
            if (take) pidx++;
            if (u_if.out_valid) begin
                if (nidx == 0) check_eq("w0_latency", cyc, 7);
                if (nidx < exp_q.size())
                    check_eq($sformatf("word%0d", nidx), u_if.data_out, exp_q[nidx]);
                else
                    check_eq("word_count", nidx + 1, exp_q.size());
                check_eq($sformatf("fin_at%0d", nidx), u_if.fin, nidx == exp_q.size() - 1);
                obs_q.push_back(u_if.data_out);
                nidx++;
                if (u_if.fin) fin_seen = 1;
            end
        end
        u_if.payload_valid = 1'b0;
        check_eq("fin_seen", fin_seen, 1);
        check_eq("word_total", nidx, exp_q.size());
        check_eq("busy_after_fin", u_if.busy, 0);
        if (f_len == 0) check_eq("ready_len0", rdy_seen, 0);
    endtask

    initial begin
        int    got;
        bit    any_out;
        string hello;
        u_if.start = 0; u_if.type_of_ser = 0; u_if.payload_len = 0; u_if.identification = 0;
        u_if.flag = 0; u_if.frag_offset = 0; u_if.time_to_live = 0; u_if.protocol = 0;
        u_if.src_ip = 0; u_if.dest_ip = 0; u_if.payload_data = 0; u_if.payload_valid = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", u_if.out_valid, 0);
        check_eq("rst_busy", u_if.busy, 0);
        check_eq("rst_fin", u_if.fin, 0);
        check_eq("rst_err", u_if.err, 0);
        check_eq("rst_data", u_if.data_out, 0);
        check_eq("rst_ready", u_if.payload_ready, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reference frame: "Hello World" over UDP.
        hello = "Hello World";
        f_tos = 8'h00; f_len = 11; f_id = 16'h1234; f_flag = 3'd0; f_frag = 13'h123;
        f_ttl = 8'h10; f_proto = 8'd17; f_src = 32'h9801331b; f_dst = 32'h980e5e4b;
        f_pl = {};
        for (int i = 0; i < hello.len(); i++) f_pl.push_back(hello[i]);
        run_frame(0, 0);
        if (obs_q.size() >= 8) begin
            check_eq("hello_w0", obs_q[0], 32'h4500001f);
            check_eq("hello_w2", obs_q[2], 32'h1011d601);
            check_eq("hello_last", obs_q[7], 32'h726c6400);
        end else begin
            check_eq("hello_size", obs_q.size(), 8);
        end

        rand_fields(0);
        run_frame(0, 0);
        rand_fields(8);
        run_frame(60, 0);
        rand_fields(20);
        run_frame(30, 1);

        // Oversize length: error pulse, no frame.
        rand_fields(0);
        f_len = 65516;
        pulse_start();
        check_eq("err_pulse", u_if.err, 1);
        check_eq("err_busy", u_if.busy, 0);
        any_out = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) check_eq("err_clear", u_if.err, 0);
            if (u_if.out_valid || u_if.busy) any_out = 1;
        end
        check_eq("err_no_output", any_out, 0);

        // Largest legal length is accepted; abandon it with reset.
        f_len = 65515;
        pulse_start();
        check_eq("max_len_err", u_if.err, 0);
        check_eq("max_len_busy", u_if.busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("max_len_abort", u_if.busy, 0);

        // Reset while the second header word is on the output.
        rand_fields(12);
        pulse_start();
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            @(posedge clk);
            #1;
            if (u_if.out_valid) got++;
        end
        check_eq("rst_mid_words", got, 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rst_mid_valid", u_if.out_valid, 0);
        check_eq("rst_mid_busy", u_if.busy, 0);
        check_eq("rst_mid_fin", u_if.fin, 0);
        rand_fields(12);
        run_frame(20, 0);

        // Back-to-back random frames.
        for (int k = 0; k < 12; k++) begin
            rand_fields($urandom_range(0, 40));
            run_frame($urandom_range(0, 60), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
